// File: rtl/hex_display_scanner_pkg.sv
// Shared types and helpers for the hex display scanner: digit limits, nibble type
// and the leading-zero blanking mask.
package hex_display_pkg;

  localparam int MAX_DIGITS = 8;

  typedef logic [3:0] nibble_t;

  // Bit i is set when nibbles i..num_digits-1 are all zero; digit 0 is never blanked.
  function automatic logic [MAX_DIGITS-1:0] lead_blank_mask(
    input logic [4*MAX_DIGITS-1:0] word,
    input int                      num_digits
  );
    logic [MAX_DIGITS-1:0] mask;
    logic                  zero_so_far;
    mask        = '0;
    zero_so_far = 1'b1;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      if (i < num_digits) begin
        zero_so_far = zero_so_far && (word[4*i +: 4] == 4'h0);
        mask[i]     = zero_so_far && (i != 0);
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/hex_display_scanner_prescaler.sv
// Refresh prescaler: free-running 0..REFRESH_DIV-1 counter with a terminal-count pulse.
module scan_prescaler #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] presc_reg;

  assign tick = (presc_reg == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_reg <= '0;
    end else if (tick) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + 1'b1;
    end
  end

endmodule

// File: rtl/hex_display_scanner.sv
// Multiplexed hex display scanner: double-buffered load with frame-boundary commit,
// one-hot digit scan and optional leading-zero blanking.
module hex_display_scanner
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int REFRESH_DIV   = 50000,
  parameter int BLANK_LEADING = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic [3:0]              digit_nibble,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    digit_blank
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] disp_reg;
  logic [4*NUM_DIGITS-1:0] pend_reg;
  logic                    pend_full_reg;
  logic [IW-1:0]           idx_reg;
  logic                    tick;
  logic                    frame_end;
  logic                    accept;
  logic                    commit;
  nibble_t                 nib [NUM_DIGITS];
  logic [MAX_DIGITS-1:0]   blank_mask;

  scan_prescaler #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_presc (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
    assign nib[gi] = disp_reg[4*gi +: 4];
  end

  assign blank_mask = lead_blank_mask((4*MAX_DIGITS)'(disp_reg), NUM_DIGITS);
  assign frame_end  = tick && (idx_reg == LAST_IDX);
  assign accept     = load_valid && load_ready;
  // Accept and commit are exclusive: accept needs an empty buffer, commit a full one.
  assign commit     = frame_end && pend_full_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_reg <= '0;
    end else if (tick) begin
      idx_reg <= frame_end ? '0 : idx_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_reg      <= '0;
      pend_full_reg <= 1'b0;
      load_ready    <= 1'b1;
      disp_reg      <= '0;
    end else begin
      if (accept) begin
        pend_reg      <= load_data;
        pend_full_reg <= 1'b1;
        load_ready    <= 1'b0;
      end else if (commit) begin
        pend_full_reg <= 1'b0;
        load_ready    <= 1'b1;
      end
      if (commit) begin
        disp_reg <= pend_reg;
      end
    end
  end

  // Outputs are registered from the pre-edge index and committed value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_en     <= '0;
      digit_nibble <= 4'h0;
      digit_blank  <= 1'b1;
    end else begin
      digit_en     <= NUM_DIGITS'(1) << idx_reg;
      digit_nibble <= nib[idx_reg];
      digit_blank  <= (BLANK_LEADING != 0) ? blank_mask[idx_reg] : 1'b0;
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Self-checking bench for hex_display_scanner (8 digits, refresh divider 4, leading-zero blanking).
module tb_hex_display_scanner;

  localparam int ND = 8;
  localparam int RD = 4;
  localparam int FR = ND * RD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = 32'h0;
  logic        load_ready;
  logic [3:0]  digit_nibble;
  logic [7:0]  digit_en;
  logic        digit_blank;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: edge counter since reset drives the scan position arithmetically.
  int          m_n = 0;
  logic [31:0] m_disp = 32'h0;
  logic [31:0] m_pend = 32'h0;
  logic        m_full = 1'b0;
  logic        m_acc = 1'b0;
  logic [7:0]  m_en = 8'h0;
  logic [3:0]  m_nib = 4'h0;
  logic        m_blank = 1'b1;

  always #5 clk = ~clk;

  hex_display_scanner #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLANK_LEADING(1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .digit_nibble(digit_nibble),
    .digit_en    (digit_en),
    .digit_blank (digit_blank)
  );

  initial begin
    int  d;
    logic commit;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_n = 0; m_disp = 32'h0; m_pend = 32'h0; m_full = 1'b0; m_acc = 1'b0;
        m_en = 8'h0; m_nib = 4'h0; m_blank = 1'b1;
      end else begin
        d = (m_n / RD) % ND;
        m_n++;
        m_en    = 8'(1 << d);
        m_nib   = 4'(m_disp >> (4 * d));
        m_blank = (d != 0) && ((m_disp >> (4 * d)) == 32'h0);
        commit  = (m_n % FR == 0) && m_full;
        m_acc   = load_valid && !m_full;
        if (commit) begin m_disp = m_pend; m_full = 1'b0; end
        if (m_acc) begin m_pend = load_data; m_full = 1'b1; end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (digit_en !== 8'h00) begin n_fail++; $display("FAIL reset_en: got %h want 00", digit_en); end
    n_checks++; if (digit_blank !== 1'b1) begin n_fail++; $display("FAIL reset_blank: got %b want 1", digit_blank); end
    n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", load_ready); end
    n_checks++; if (digit_nibble !== 4'h0) begin n_fail++; $display("FAIL reset_nib: got %h want 0", digit_nibble); end
    reset = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      n_checks++;
      if (digit_en !== 8'(1 << (((k - 1) / RD) % ND))) begin
        n_fail++; $display("FAIL scan_step%0d: got en=%h want %h", k, digit_en, 8'(1 << (((k - 1) / RD) % ND)));
      end
      n_checks++;
      if ({digit_en, digit_nibble, digit_blank, load_ready} !== {m_en, m_nib, m_blank, ~m_full}) begin
        n_fail++; $display("FAIL reset_scan@%0d: got %h want %h", m_n, {digit_en, digit_nibble, digit_blank, load_ready}, {m_en, m_nib, m_blank, ~m_full});
      end
    end
    $display("test_reset done: %0d checks, %0d failures so far", n_checks, n_fail);
  endtask

  task automatic test_load_commit();
    logic [31:0] words [3];
    logic [31:0] w;
    int guard;
    words[0] = 32'hDEADBEEF; words[1] = 32'h00000A30; words[2] = 32'h00000000;
    for (int t = 0; t < 3; t++) begin
      w = words[t];
      guard = 0;
      while ((m_n % FR != 10) && guard < 2 * FR) begin @(negedge clk); guard++; end
      load_valid = 1'b1; load_data = w;
      @(negedge clk);
      load_valid = 1'b0;
      n_checks++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL load_ready_fall %h: got %b want 0", w, load_ready); end
      guard = 0;
      while (load_ready !== 1'b1 && guard < 2 * FR) begin
        @(negedge clk); guard++;
        n_checks++;
        if ({digit_en, digit_nibble, digit_blank, load_ready} !== {m_en, m_nib, m_blank, ~m_full}) begin
          n_fail++; $display("FAIL hold_scan@%0d: got %h want %h", m_n, {digit_en, digit_nibble, digit_blank, load_ready}, {m_en, m_nib, m_blank, ~m_full});
        end
      end
      n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL commit_timeout %h: ready=%b want 1", w, load_ready); end
      n_checks++; if (digit_en !== 8'h80) begin n_fail++; $display("FAIL commit_edge_en %h: got %h want 80", w, digit_en); end
      for (int j = 0; j < FR; j++) begin
        @(negedge clk);
        n_checks++;
        if (digit_nibble !== 4'(w >> (4 * (j / RD))) || digit_blank !== ((j / RD != 0) && ((w >> (4 * (j / RD))) == 0))
            || digit_en !== 8'(1 << (j / RD))) begin
          n_fail++; $display("FAIL show_%h_digit%0d: got nib=%h blank=%b en=%h want nib=%h blank=%b en=%h", w, j / RD,
            digit_nibble, digit_blank, digit_en, 4'(w >> (4 * (j / RD))), ((j / RD != 0) && ((w >> (4 * (j / RD))) == 0)), 8'(1 << (j / RD)));
        end
      end
      $display("test_load_commit word %h done: %0d checks, %0d failures so far", w, n_checks, n_fail);
    end
  endtask

  task automatic test_frame_end_load();
    int guard = 0;
    while ((m_n % FR != FR - 1) && guard < 2 * FR) begin @(negedge clk); guard++; end
    load_valid = 1'b1; load_data = 32'h12345678;
    @(negedge clk);
    load_valid = 1'b0;
    n_checks++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL fe_accept: ready=%b want 0", load_ready); end
    @(negedge clk);
    n_checks++; if (digit_en !== 8'h01 || digit_nibble !== 4'h0) begin
      n_fail++; $display("FAIL fe_not_committed: got en=%h nib=%h want en=01 nib=0", digit_en, digit_nibble);
    end
    repeat (FR - 1) begin
      @(negedge clk);
      n_checks++;
      if ({digit_en, digit_nibble, digit_blank, load_ready} !== {m_en, m_nib, m_blank, ~m_full}) begin
        n_fail++; $display("FAIL fe_scan@%0d: got %h want %h", m_n, {digit_en, digit_nibble, digit_blank, load_ready}, {m_en, m_nib, m_blank, ~m_full});
      end
    end
    n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL fe_late_commit_ready: got %b want 1", load_ready); end
    @(negedge clk);
    n_checks++; if (digit_en !== 8'h01 || digit_nibble !== 4'h8) begin
      n_fail++; $display("FAIL fe_late_commit_show: got en=%h nib=%h want en=01 nib=8", digit_en, digit_nibble);
    end
    $display("test_frame_end_load done: %0d checks, %0d failures so far", n_checks, n_fail);
  endtask

  task automatic test_back_to_back();
    int   guard = 0;
    logic saw1 = 1'b0;
    logic saw2 = 1'b0;
    logic prev_ready;
    load_valid = 1'b1; load_data = 32'h11111111;
    prev_ready = load_ready;
    while (!saw2 && guard < 8 * FR) begin
      @(negedge clk); guard++;
      n_checks++;
      if ({digit_en, digit_nibble, digit_blank, load_ready} !== {m_en, m_nib, m_blank, ~m_full}) begin
        n_fail++; $display("FAIL b2b_scan@%0d: got %h want %h", m_n, {digit_en, digit_nibble, digit_blank, load_ready}, {m_en, m_nib, m_blank, ~m_full});
      end
      if (m_acc && load_valid) begin
        if (load_data == 32'h11111111) begin
          load_data = 32'h22222222;
        end else begin
          n_checks++;
          if (prev_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_second_early: ready before accept=%b want 1", prev_ready); end
          load_valid = 1'b0;
        end
      end
      if (digit_en == 8'h01 && digit_nibble == 4'h1) saw1 = 1'b1;
      if (saw1 && digit_en == 8'h01 && digit_nibble == 4'h2) saw2 = 1'b1;
      prev_ready = load_ready;
    end
    load_valid = 1'b0;
    n_checks++; if (saw1 !== 1'b1) begin n_fail++; $display("FAIL b2b_first_shown: got %b want 1", saw1); end
    n_checks++; if (saw2 !== 1'b1) begin n_fail++; $display("FAIL b2b_second_shown: got %b want 1", saw2); end
    $display("test_back_to_back done: %0d checks, %0d failures so far", n_checks, n_fail);
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      n_checks++;
      if ({digit_en, digit_nibble, digit_blank, load_ready} !== {m_en, m_nib, m_blank, ~m_full}) begin
        n_fail++; $display("FAIL rand_scan@%0d: got %h want %h", m_n, {digit_en, digit_nibble, digit_blank, load_ready}, {m_en, m_nib, m_blank, ~m_full});
      end
      if (!(load_valid && !m_acc)) begin
        load_valid = ($urandom_range(0, 5) == 0);
        load_data  = $urandom >> (4 * $urandom_range(0, 8));
      end
    end
    load_valid = 1'b0;
    $display("test_random done: %0d checks, %0d failures so far", n_checks, n_fail);
  endtask

  task automatic test_reset_midframe();
    int guard = 0;
    while ((m_full || (m_n % FR != 5)) && guard < 4 * FR) begin @(negedge clk); guard++; end
    load_valid = 1'b1; load_data = 32'h99999999;
    @(negedge clk);
    load_valid = 1'b0;
    n_checks++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL mid_pend_full: ready=%b want 0", load_ready); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (digit_en !== 8'h00) begin n_fail++; $display("FAIL async_reset_en: got %h want 00", digit_en); end
    n_checks++; if (digit_blank !== 1'b1) begin n_fail++; $display("FAIL async_reset_blank: got %b want 1", digit_blank); end
    n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL async_reset_ready: got %b want 1", load_ready); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 2 * FR; k++) begin
      @(negedge clk);
      n_checks++;
      if (digit_nibble !== 4'h0 || digit_blank !== (digit_en != 8'h01)) begin
        n_fail++; $display("FAIL discarded_word: got nib=%h blank=%b en=%h want nib=0", digit_nibble, digit_blank, digit_en);
      end
      n_checks++;
      if ({digit_en, digit_nibble, digit_blank, load_ready} !== {m_en, m_nib, m_blank, ~m_full}) begin
        n_fail++; $display("FAIL post_reset_scan@%0d: got %h want %h", m_n, {digit_en, digit_nibble, digit_blank, load_ready}, {m_en, m_nib, m_blank, ~m_full});
      end
    end
    $display("test_reset_midframe done: %0d checks, %0d failures so far", n_checks, n_fail);
  endtask

  initial begin
    test_reset();
    test_load_commit();
    test_frame_end_load();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
